ps2_key_event_tracker: RTL

- Synchronous successor to the top-level PS2 make/break decoder.
- Consumes the one-cycle byte strobe from PS2_Controller on the system clock; no clocking on the data strobe.
- Maintains a held-key vector for a parametrised, scancode-mapped key set, and handles F0 break and E0 extended prefixes.
- Emits press/release pulses and queues press/release events in a FIFO consumed by MasterFSM / mainStateHandler.

---
 rtl/ps2_key_event_tracker.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/ps2_key_event_tracker.sv
// ----------------------------------------------------------------------------
// ps2_key_event_tracker
//
// Purpose:
//   Turns the byte stream from PS2_Controller into key state for a fixed,
//   scancode-mapped set of keys. Handles the F0 (break) and E0 (extended)
//   prefixes, keeps a held-key vector, pulses on press/release edges and
//   queues press/release events in a small first-word-fall-through FIFO for
//   MasterFSM / mainStateHandler. Everything runs on the system clock; the
//   byte strobe is sampled as an ordinary synchronous input.
//
// Ports:
//   CLOCK_50       in   system clock
//   resetn         in   asynchronous active-low reset
//   rx_data        in   received PS2 byte
//   rx_valid       in   one-cycle strobe, rx_data valid this cycle
//   clear_all      in   synchronous clear of keys, FIFO, overflow, decoder
//   key_state      out  bit i set while key i is held
//   any_key_down   out  OR of key_state
//   press_pulse    out  one cycle when a tracked key goes up->down
//   release_pulse  out  one cycle when a tracked key goes down->up
//   evt_valid      out  FIFO head valid
//   evt_ready      in   consumer pops the head when evt_valid && evt_ready
//   evt_release    out  head event type (0 press, 1 release)
//   evt_key        out  head key index
//   evt_count      out  FIFO occupancy
//   overflow       out  sticky, an event was dropped because the FIFO was full
// ----------------------------------------------------------------------------
module ps2_key_event_tracker #(
    parameter int NUM_KEYS   = 29,
    parameter int KEY_IDX_W  = 5,
    parameter logic [8*NUM_KEYS-1:0] KEYMAP = {
        8'h29, 8'h5D, 8'h5B, 8'h54, 8'h4D, 8'h44, 8'h43, 8'h3C,
        8'h35, 8'h2C, 8'h2D, 8'h24, 8'h1D, 8'h15, 8'h0D, 8'h66,
        8'h55, 8'h4E, 8'h45, 8'h46, 8'h3E, 8'h3D, 8'h36, 8'h2E,
        8'h25, 8'h26, 8'h1E, 8'h16, 8'h0E
    },
    parameter int FIFO_DEPTH = 8
) (
    input  logic                            CLOCK_50,
    input  logic                            resetn,
    input  logic [7:0]                      rx_data,
    input  logic                            rx_valid,
    input  logic                            clear_all,
    output logic [NUM_KEYS-1:0]             key_state,
    output logic                            any_key_down,
    output logic                            press_pulse,
    output logic                            release_pulse,
    output logic                            evt_valid,
    input  logic                            evt_ready,
    output logic                            evt_release,
    output logic [KEY_IDX_W-1:0]            evt_key,
    output logic [$clog2(FIFO_DEPTH):0]     evt_count,
    output logic                            overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        BRK,
        EXT,
        EXT_BRK
    } decodeState_e;

    decodeState_e state;
    decodeState_e nextState;

    logic                 isMake;
    logic                 isBreak;
    logic                 keyHit;
    logic [KEY_IDX_W-1:0] keyIdx;
    logic                 keyHeld;
    logic                 doPress;
    logic                 doRelease;

    logic [KEY_IDX_W:0]   fifoMem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wrPtr;
    logic [PTR_W-1:0]     rdPtr;
    logic [CNT_W-1:0]     fifoCount;
    logic                 fifoFull;
    logic                 pushNow;
    logic                 popNow;
    logic                 writeNow;
    logic [KEY_IDX_W:0]   pushData;
    logic [KEY_IDX_W:0]   headEntry;

    // Decoder state register. The FSM only tracks which prefix bytes have
    // been seen since the last complete code.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state and byte classification. A byte in IDLE that is not a
    // prefix is a make code; any byte after a lone F0 is a break code.
    // Extended sequences (E0 xx, E0 F0 xx) are consumed and ignored since
    // none of the tracked keys live in the extended set. clear_all wins
    // over a byte arriving in the same cycle, so the byte is discarded.
    always_comb begin
        nextState = state;
        isMake    = 1'b0;
        isBreak   = 1'b0;
        if (clear_all) begin
            nextState = IDLE;
        end else if (rx_valid) begin
            case (state)
                IDLE: begin
                    if (rx_data == 8'hF0) begin
                        nextState = BRK;
                    end else if (rx_data == 8'hE0) begin
                        nextState = EXT;
                    end else begin
                        isMake = 1'b1;
                    end
                end
                BRK: begin
                    isBreak   = 1'b1;
                    nextState = IDLE;
                end
                EXT: begin
                    if (rx_data == 8'hF0) begin
                        nextState = EXT_BRK;
                    end else begin
                        nextState = IDLE;
                    end
                end
                EXT_BRK: begin
                    nextState = IDLE;
                end
                default: begin
                    nextState = IDLE;
                end
            endcase
        end
    end

    // Scancode lookup. Walking from the top index down means the lowest
    // matching index is the one left standing if the keymap has duplicates.
    always_comb begin
        keyHit = 1'b0;
        keyIdx = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (KEYMAP[8*i +: 8] == rx_data) begin
                keyHit = 1'b1;
                keyIdx = KEY_IDX_W'(i);
            end
        end
    end

    // Edge detection against the held vector: repeats of a held key and
    // breaks of a key that is not held are filtered out here, so only real
    // transitions generate pulses and events.
    assign keyHeld   = key_state[keyIdx];
    assign doPress   = isMake  && keyHit && !keyHeld;
    assign doRelease = isBreak && keyHit &&  keyHeld;

    // Held-key vector and the one-cycle transition pulses.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            key_state     <= '0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else if (clear_all) begin
            key_state     <= '0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            press_pulse   <= doPress;
            release_pulse <= doRelease;
            if (doPress) begin
                key_state[keyIdx] <= 1'b1;
            end
            if (doRelease) begin
                key_state[keyIdx] <= 1'b0;
            end
        end
    end

    assign any_key_down = |key_state;

    // FIFO control. A pop frees a slot in the same cycle, so a full FIFO
    // still accepts a push when the consumer is popping. A pop request while
    // empty is meaningless and is masked by evt_valid.
    assign pushNow  = doPress || doRelease;
    assign pushData = {doRelease, keyIdx};
    assign fifoFull = (fifoCount == CNT_W'(FIFO_DEPTH));
    assign popNow   = evt_valid && evt_ready;
    assign writeNow = pushNow && (!fifoFull || popNow);

    // Event storage. No reset is needed on the array: entries are only read
    // while the occupancy says they hold data.
    always_ff @(posedge CLOCK_50) begin
        if (writeNow) begin
            fifoMem[wrPtr] <= pushData;
        end
    end

    // Pointers, occupancy and the sticky overflow flag. Pointers are exactly
    // PTR_W bits wide, so incrementing wraps modulo FIFO_DEPTH by itself.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            fifoCount <= '0;
            overflow  <= 1'b0;
        end else if (clear_all) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            fifoCount <= '0;
            overflow  <= 1'b0;
        end else begin
            if (writeNow) begin
                wrPtr <= wrPtr + PTR_W'(1);
            end
            if (popNow) begin
                rdPtr <= rdPtr + PTR_W'(1);
            end
            case ({writeNow, popNow})
                2'b10:   fifoCount <= fifoCount + CNT_W'(1);
                2'b01:   fifoCount <= fifoCount - CNT_W'(1);
                default: fifoCount <= fifoCount;
            endcase
            if (pushNow && fifoFull && !popNow) begin
                overflow <= 1'b1;
            end
        end
    end

    // Head of queue straight from storage (fall-through). The head fields
    // are forced to zero while empty so stale entries never leak out.
    assign headEntry   = fifoMem[rdPtr];
    assign evt_valid   = (fifoCount != '0);
    assign evt_release = evt_valid ? headEntry[KEY_IDX_W] : 1'b0;
    assign evt_key     = evt_valid ? headEntry[KEY_IDX_W-1:0] : '0;
    assign evt_count   = fifoCount;

endmodule
